// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : instr_fetch_unit_if
// Purpose  : Instruction-memory req/ack port. The fetch unit is the master:
//            it raises req with addr and waits for ack, which comes with rdata.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
interface instr_fetch_unit_if #(
  parameter int AW = 32
);
  logic          req;
  logic [AW-1:0] addr;
  logic          ack;
  logic [31:0]   rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : instr_fetch_unit
// Purpose  : Fetch stage. Owns the PC, fetches one word per instruction over a
//            req/ack port and holds it in the instruction register. It retires
//            the instruction when stall is low and then moves to next-PC
//            (jump > branch > sequential).
// Options  : FETCH_PERF_CNT_EN - when defined, retired_cnt counts retires.
//            When it is not defined, retired_cnt is tied to zero.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 32
) (
  input  wire logic               clk,
  input  wire logic               rst,
  instr_fetch_unit_if.master      imem,
  input  wire logic               stall,
  input  wire logic               PCSRC,
  input  wire logic               jump,
  output logic [31:0]             instr,
  output logic [5:0]              Opcode,
  output logic [5:0]              Funct,
  output logic                    instr_valid,
  output logic [IMEM_AW-1:0]      pc,
  output logic [IMEM_AW-1:0]      pc_plus4,
  output logic [31:0]             retired_cnt
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic               capture;   // ack accepted this cycle
  logic               retire;    // instruction leaves the stage this cycle
  logic [IMEM_AW-1:0] br_off;
  logic [IMEM_AW-1:0] next_pc;

  // Request and valid are decoded from the state. A reset therefore drops
  // the request as soon as the state register clears, without waiting for a
  // clock edge.
  assign imem.addr = pc;
  assign Opcode    = instr[31:26];
  assign Funct     = instr[5:0];
  assign pc_plus4  = pc + {{(IMEM_AW-3){1'b0}}, 3'b100};

  // Word offset of the branch, sign-extended and scaled to bytes.
  assign br_off = {{(IMEM_AW-18){instr[15]}}, instr[15:0], 2'b00};

  // Next-PC select. Jump has priority over a taken branch.
  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = {pc_plus4[IMEM_AW-1:28], instr[25:0], 2'b00};
    end else if (PCSRC) begin
      next_pc = pc_plus4 + br_off;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and state-decoded control outputs.
  always_comb begin
    state_nxt   = state;
    imem.req    = 1'b0;
    instr_valid = 1'b0;
    capture     = 1'b0;
    retire      = 1'b0;
    case (state)
      S_BOOT: begin
        state_nxt = S_REQ;
      end
      S_REQ: begin
        imem.req = 1'b1;
        if (imem.ack) begin
          capture   = 1'b1;
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        instr_valid = 1'b1;
        if (!stall) begin
          retire    = 1'b1;
          state_nxt = S_REQ;
        end
      end
      default: begin
        state_nxt = S_BOOT;
      end
    endcase
  end

  // Instruction register: loaded only on an accepted ack. It is held while
  // the stage is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr <= 32'h0;
    end else if (capture) begin
      instr <= imem.rdata;
    end
  end

  // PC register: advances only when the held instruction retires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC[IMEM_AW-1:0];
    end else if (retire) begin
      pc <= next_pc;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Retired-instruction counter. It wraps naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_cnt <= 32'h0;
    end else if (retire) begin
      retired_cnt <= retired_cnt + 32'd1;
    end
  end
`else
  assign retired_cnt = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_instr_fetch_unit
// Purpose  : Self-checking bench for instr_fetch_unit. A table of instruction
//            records walks a PC path of branches, jumps and wraps. A reset
//            sequence is written out by hand.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        PCSRC;
  logic        jump;
  logic [31:0] instr;
  logic [5:0]  Opcode;
  logic [5:0]  Funct;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] retired_cnt;

  instr_fetch_unit_if #(.AW(32)) imem_bus ();

  instr_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .IMEM_AW  (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem        (imem_bus),
    .stall       (stall),
    .PCSRC       (PCSRC),
    .jump        (jump),
    .instr       (instr),
    .Opcode      (Opcode),
    .Funct       (Funct),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .retired_cnt (retired_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        pcsrc;
    logic        jump;
    int          ack_dly;
    int          stall_cyc;
    logic [31:0] exp_next;
  } vec_t;

  vec_t        vecs[15];
  logic [31:0] exp_q[$];
  logic [31:0] exp_ret;
  int          checks;
  int          failures;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%08h expected=%08h", nm, act, exp);
    end
  endtask

  // Serve one fetch: wait for the request, compare its address with the
  // scoreboard, acknowledge after ack_dly cycles, optionally stall, then
  // retire with the record's branch/jump flags.
  task automatic fetch(input vec_t v);
    int          n;
    logic [31:0] a;
    logic [31:0] e;
    logic [7:0]  op;
    logic [7:0]  fn;
    n = 0;
    while (imem_bus.req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (imem_bus.req !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL req_timeout actual=%0b expected=1", imem_bus.req);
      return;
    end
    a = imem_bus.addr;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else                  e = 32'hDEAD_BEEF;
    check("fetch_addr", a, e);
    for (int i = 0; i < v.ack_dly; i++) begin
      imem_bus.ack   = 1'b0;
      imem_bus.rdata = $urandom;
      @(negedge clk);
      check("req_held", {31'h0, imem_bus.req}, 32'h1);
      check("addr_stable", imem_bus.addr, a);
    end
    imem_bus.ack   = 1'b1;
    imem_bus.rdata = v.instr;
    @(negedge clk);
    imem_bus.rdata = $urandom;
    op = {2'b00, v.instr[31:26]};
    fn = {2'b00, v.instr[5:0]};
    check("valid_hold", {31'h0, instr_valid}, 32'h1);
    check("req_low_hold", {31'h0, imem_bus.req}, 32'h0);
    check("instr", instr, v.instr);
    check("opcode", {26'h0, Opcode}, {24'h0, op});
    check("funct", {26'h0, Funct}, {24'h0, fn});
    check("pc", pc, a);
    check("pc_plus4", pc_plus4, a + 32'd4);
    check("retired_cnt", retired_cnt, exp_ret);
    for (int i = 0; i < v.stall_cyc; i++) begin
      stall = 1'b1;
      PCSRC = 1'b1;
      jump  = 1'b1;
      @(negedge clk);
      check("stall_valid", {31'h0, instr_valid}, 32'h1);
      check("stall_instr", instr, v.instr);
      check("stall_pc", pc, a);
      check("stall_cnt", retired_cnt, exp_ret);
    end
    stall = 1'b0;
    PCSRC = v.pcsrc;
    jump  = v.jump;
    exp_q.push_back(v.exp_next);
`ifdef FETCH_PERF_CNT_EN
    exp_ret = exp_ret + 32'd1;
`endif
    @(negedge clk);
    PCSRC = 1'b0;
    jump  = 1'b0;
    check("valid_pulse", {31'h0, instr_valid}, 32'h0);
    check("retired_after", retired_cnt, exp_ret);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    exp_ret  = 32'h0;

    // instr, pcsrc, jump, ack delay, stall cycles, expected next fetch addr
    vecs[0]  = '{32'hAC22_0025, 1'b0, 1'b0, 0, 0, 32'h0000_0004};
    vecs[1]  = '{32'h8C43_0004, 1'b0, 1'b0, 0, 0, 32'h0000_0008};
    vecs[2]  = '{32'h0000_0020, 1'b0, 1'b0, 0, 0, 32'h0000_000C};
    vecs[3]  = '{32'h0800_0004, 1'b0, 1'b1, 0, 0, 32'h0000_0010};
    vecs[4]  = '{32'h1000_0003, 1'b1, 1'b0, 0, 0, 32'h0000_0020};
    vecs[5]  = '{32'h0800_0004, 1'b0, 1'b1, 0, 0, 32'h0000_0010};
    vecs[6]  = '{32'h1000_FFFF, 1'b1, 1'b0, 0, 0, 32'h0000_0010};
    vecs[7]  = '{32'h1000_0003, 1'b0, 1'b0, 5, 3, 32'h0000_0014};
    vecs[8]  = '{32'h1000_0003, 1'b0, 1'b0, 1, 2, 32'h0000_0018};
    vecs[9]  = '{32'h0800_0002, 1'b1, 1'b1, 0, 1, 32'h0000_0008};
    vecs[10] = '{32'h0800_0040, 1'b1, 1'b1, 0, 0, 32'h0000_0100};
    vecs[11] = '{32'h1000_FFBF, 1'b1, 1'b0, 0, 0, 32'h0000_0000};
    vecs[12] = '{32'h1000_FFFE, 1'b1, 1'b0, 0, 0, 32'hFFFF_FFFC};
    vecs[13] = '{32'h1000_0003, 1'b0, 1'b0, 0, 0, 32'h0000_0000};
    vecs[14] = '{32'h0800_0010, 1'b0, 1'b1, 0, 0, 32'h0000_0040};

    rst            = 1'b1;
    stall          = 1'b0;
    PCSRC          = 1'b0;
    jump           = 1'b0;
    imem_bus.ack   = 1'b1;
    imem_bus.rdata = 32'h1234_5678;

    repeat (3) @(negedge clk);
    check("rst_req", {31'h0, imem_bus.req}, 32'h0);
    check("rst_valid", {31'h0, instr_valid}, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_pc", pc, 32'h0);
    check("rst_addr", imem_bus.addr, 32'h0);
    check("rst_opfn", {20'h0, Opcode, Funct}, 32'h0);
    check("rst_cnt", retired_cnt, 32'h0);

    rst = 1'b0;
    exp_q.push_back(32'h0000_0000);
    check("boot_idle", {31'h0, imem_bus.req}, 32'h0);
    @(negedge clk);

    for (int k = 0; k < 15; k++) begin
      fetch(vecs[k]);
    end

    // Reset while a request to 0x40 is outstanding. An ack that arrives
    // during reset must be ignored.
    if (exp_q.size() > 0) check("pre_rst_addr", imem_bus.addr, exp_q.pop_front());
    check("pre_rst_req", {31'h0, imem_bus.req}, 32'h1);
    imem_bus.ack = 1'b0;
    #2;
    rst            = 1'b1;
    imem_bus.ack   = 1'b1;
    imem_bus.rdata = 32'hFFFF_FFFF;
    #1;
    check("async_req_drop", {31'h0, imem_bus.req}, 32'h0);
    check("async_pc", pc, 32'h0);
    check("async_valid", {31'h0, instr_valid}, 32'h0);
    check("async_instr", instr, 32'h0);
    check("async_cnt", retired_cnt, 32'h0);
    repeat (2) @(negedge clk);
    check("in_rst_req", {31'h0, imem_bus.req}, 32'h0);
    check("in_rst_instr", instr, 32'h0);
    rst          = 1'b0;
    imem_bus.ack = 1'b0;
    exp_ret      = 32'h0;
    exp_q.delete();
    exp_q.push_back(32'h0000_0000);
    check("post_rst_boot", {31'h0, imem_bus.req}, 32'h0);
    @(negedge clk);
    check("post_rst_req", {31'h0, imem_bus.req}, 32'h1);
    imem_bus.ack = 1'b1;

    for (int k = 0; k < 3; k++) begin
      fetch(vecs[k]);
    end
    check("final_addr", imem_bus.addr, 32'h0000_000C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
